// File: rtl/adc_config_pkg.sv
// Shared constants and helpers for the ADC front-end AXI4-Lite register bank:
// word indices, response codes, config word 0 bit positions and decode helpers.
package adc_config_pkg;

   localparam int CFG_BASE    = 0;
   localparam int STATUS_BASE = 16;
   localparam int CMD_DATA    = 32;
   localparam int CMD_LEVEL   = 33;
   localparam int CMD_CTRL    = 34;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CFG0_ADC_RSTN     = 0;
   localparam int CFG0_DMA_RSTN     = 1;
   localparam int CFG0_PKT_RSTN     = 2;
   localparam int CFG0_PWR_EN       = 3;
   localparam int CFG0_REF_EN       = 4;
   localparam int CFG0_IO_EN        = 5;
   localparam int CFG0_DIFFAMP_EN   = 6;
   localparam int CFG0_OPAMP_EN     = 7;

   typedef enum logic [2:0] {
      REG_CFG,
      REG_STATUS,
      REG_CMD_DATA,
      REG_CMD_LEVEL,
      REG_CMD_CTRL,
      REG_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode_index(input int idx, input int num_cfg,
                                             input int num_status);
      if (idx >= CFG_BASE && idx < CFG_BASE + num_cfg)           return REG_CFG;
      if (idx >= STATUS_BASE && idx < STATUS_BASE + num_status)  return REG_STATUS;
      if (idx == CMD_DATA)                                       return REG_CMD_DATA;
      if (idx == CMD_LEVEL)                                      return REG_CMD_LEVEL;
      if (idx == CMD_CTRL)                                       return REG_CMD_CTRL;
      return REG_NONE;
   endfunction

   // Byte-strobe merge: each set strobe bit replaces the matching byte.
   function automatic logic [31:0] write_register(input logic [31:0] old_val,
                                                  input logic [31:0] wdata,
                                                  input logic [3:0]  wstrb);
      logic [31:0] merged;
      merged = old_val;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/adc_cmd_fifo.sv
// Synchronous command FIFO with flush; count spans 0..DEPTH so full and empty
// are unambiguous even though the pointers wrap modulo DEPTH.
module adc_cmd_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];

   // A pop frees the slot the push lands in, so a full FIFO still takes it.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; count and pointers alone define which
   // entries are valid, so stale contents are never presented as data.
   always_ff @(posedge aclk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/adc_config_bank.sv
// AXI4-Lite control/status bank for the ADC front end: config words, live
// status words and a buffered command stream toward the ADC.
module adc_config_bank
   import adc_config_pkg::*;
#(
   parameter int NUM_CFG    = 2,
   parameter int NUM_STATUS = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   output logic [32*NUM_CFG-1:0]   cfg,
   input  logic [32*NUM_STATUS-1:0] status,
   output logic                    adc_resetn,
   output logic                    dma_resetn,
   output logic                    packetizer_resetn,
   output logic                    pwr_en,
   output logic                    ref_en,
   output logic                    io_en,
   output logic                    diffamp_en,
   output logic                    opamp_en,
   output logic [31:0]             m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_lite_awaddr,
   input  logic [2:0]              s_axi_lite_awprot,
   input  logic                    s_axi_lite_awvalid,
   output logic                    s_axi_lite_awready,
   input  logic [31:0]             s_axi_lite_wdata,
   input  logic [3:0]              s_axi_lite_wstrb,
   input  logic                    s_axi_lite_wvalid,
   output logic                    s_axi_lite_wready,
   output logic [1:0]              s_axi_lite_bresp,
   output logic                    s_axi_lite_bvalid,
   input  logic                    s_axi_lite_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_lite_araddr,
   input  logic [2:0]              s_axi_lite_arprot,
   input  logic                    s_axi_lite_arvalid,
   output logic                    s_axi_lite_arready,
   output logic [31:0]             s_axi_lite_rdata,
   output logic [1:0]              s_axi_lite_rresp,
   output logic                    s_axi_lite_rvalid,
   input  logic                    s_axi_lite_rready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0] cfg_q [NUM_CFG];
   logic [31:0] cfg_d [NUM_CFG];
   logic        awready_q, awready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] last_cmd_q, last_cmd_d;
   logic        ovf_q, ovf_d;

   logic             wr_acc, ar_hs;
   int               wr_idx, rd_idx;
   logic             fifo_push, fifo_pop, fifo_flush;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [31:0]      fifo_head;
   logic             unused_ok;

   assign unused_ok = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                        s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

   assign wr_idx   = int'(s_axi_lite_awaddr[ADDR_WIDTH-1:2]);
   assign rd_idx   = int'(s_axi_lite_araddr[ADDR_WIDTH-1:2]);
   assign wr_acc   = awready_q & s_axi_lite_awvalid & s_axi_lite_wvalid;
   assign ar_hs    = arready_q & s_axi_lite_arvalid;
   assign fifo_pop = ~fifo_empty & m_axis_tready;

   adc_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_cmd_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (fifo_push),
      .din     (s_axi_lite_wdata),
      .pop     (fifo_pop),
      .flush   (fifo_flush),
      .dout    (fifo_head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Ready is raised one cycle after both valids appear and only while no
   // response is outstanding, giving the three-cycle write spacing.
   always_comb begin
      // NOTE: every _d starts from its held value so no branch infers a latch.
      cfg_d      = cfg_q;
      awready_d  = s_axi_lite_awvalid & s_axi_lite_wvalid & ~bvalid_q & ~awready_q;
      bvalid_d   = bvalid_q & ~s_axi_lite_bready;
      bresp_d    = bresp_q;
      last_cmd_d = last_cmd_q;
      ovf_d      = ovf_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      if (wr_acc) begin
         bvalid_d = 1'b1;
         bresp_d  = RESP_OKAY;
         case (decode_index(wr_idx, NUM_CFG, NUM_STATUS))
            REG_CFG: begin
               for (int k = 0; k < NUM_CFG; k++) begin
                  if (wr_idx == CFG_BASE + k)
                     cfg_d[k] = write_register(cfg_q[k], s_axi_lite_wdata, s_axi_lite_wstrb);
               end
            end
            REG_CMD_DATA: begin
               if (fifo_full && !fifo_pop) begin
                  ovf_d   = 1'b1;
                  bresp_d = RESP_SLVERR;
               end else begin
                  fifo_push  = 1'b1;
                  last_cmd_d = s_axi_lite_wdata;
               end
            end
            REG_CMD_CTRL: begin
               fifo_flush = s_axi_lite_wdata[0];
               if (s_axi_lite_wdata[1]) ovf_d = 1'b0;
            end
            default: bresp_d = RESP_SLVERR;
         endcase
      end
   end

   always_comb begin
      rvalid_d = rvalid_q & ~s_axi_lite_rready;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_OKAY;
         case (decode_index(rd_idx, NUM_CFG, NUM_STATUS))
            REG_CFG: begin
               for (int k = 0; k < NUM_CFG; k++) begin
                  if (rd_idx == CFG_BASE + k) rdata_d = cfg_q[k];
               end
            end
            REG_STATUS: begin
               for (int k = 0; k < NUM_STATUS; k++) begin
                  if (rd_idx == STATUS_BASE + k) rdata_d = status[32*k +: 32];
               end
            end
            REG_CMD_DATA:  rdata_d = last_cmd_q;
            REG_CMD_LEVEL: rdata_d = {13'b0, ovf_q, fifo_empty, fifo_full, 16'(fifo_count)};
            REG_CMD_CTRL:  rdata_d = {30'b0, ovf_q, 1'b0};
            default:       rresp_d = RESP_SLVERR;
         endcase
      end
      arready_d = ~rvalid_d;
   end

   // NOTE: sequential state takes non-blocking assignments only; the blocking
   // ones above live solely in combinational next-state logic.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
         awready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         last_cmd_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         cfg_q      <= cfg_d;
         awready_q  <= awready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         last_cmd_q <= last_cmd_d;
         ovf_q      <= ovf_d;
      end
   end

   for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
      assign cfg[32*k +: 32] = cfg_q[k];
   end

   // Block resets drop with aresetn without waiting for a clock edge.
   assign adc_resetn        = cfg_q[0][CFG0_ADC_RSTN] & aresetn;
   assign dma_resetn        = cfg_q[0][CFG0_DMA_RSTN] & aresetn;
   assign packetizer_resetn = cfg_q[0][CFG0_PKT_RSTN] & aresetn;
   assign pwr_en            = cfg_q[0][CFG0_PWR_EN];
   assign ref_en            = cfg_q[0][CFG0_REF_EN];
   assign io_en             = cfg_q[0][CFG0_IO_EN];
   assign diffamp_en        = cfg_q[0][CFG0_DIFFAMP_EN];
   assign opamp_en          = cfg_q[0][CFG0_OPAMP_EN];

   assign m_axis_tdata       = fifo_head;
   assign m_axis_tvalid      = ~fifo_empty;
   assign s_axi_lite_awready = awready_q;
   assign s_axi_lite_wready  = awready_q;
   assign s_axi_lite_bvalid  = bvalid_q;
   assign s_axi_lite_bresp   = bresp_q;
   assign s_axi_lite_arready = arready_q;
   assign s_axi_lite_rvalid  = rvalid_q;
   assign s_axi_lite_rresp   = rresp_q;
   assign s_axi_lite_rdata   = rdata_q;

endmodule

// File: tb/tb_adc_config_bank.sv
// Directed bench for adc_config_bank: a queue-based register/FIFO model is
// compared every cycle, plus literal expectations for each scenario.
module tb_adc_config_bank;

   localparam int NUM_CFG    = 2;
   localparam int NUM_STATUS = 2;
   localparam int DEPTH      = 4;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] cfg;
   logic [63:0] status;
   logic        adc_resetn, dma_resetn, packetizer_resetn;
   logic        pwr_en, ref_en, io_en, diffamp_en, opamp_en;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready;
   logic [7:0]  s_axi_lite_awaddr, s_axi_lite_araddr;
   logic [2:0]  s_axi_lite_awprot, s_axi_lite_arprot;
   logic        s_axi_lite_awvalid, s_axi_lite_awready;
   logic [31:0] s_axi_lite_wdata, s_axi_lite_rdata;
   logic [3:0]  s_axi_lite_wstrb;
   logic        s_axi_lite_wvalid, s_axi_lite_wready;
   logic [1:0]  s_axi_lite_bresp, s_axi_lite_rresp;
   logic        s_axi_lite_bvalid, s_axi_lite_bready;
   logic        s_axi_lite_arvalid, s_axi_lite_arready;
   logic        s_axi_lite_rvalid, s_axi_lite_rready;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_cfg [NUM_CFG];
   logic [31:0] m_fifo [$];
   logic        m_ovf;
   logic [31:0] m_last;
   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];
   bit          b_due, r_due;

   adc_config_bank #(.NUM_CFG(NUM_CFG), .NUM_STATUS(NUM_STATUS),
                     .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(8)) dut (
      .aclk(aclk), .aresetn(aresetn), .cfg(cfg), .status(status),
      .adc_resetn(adc_resetn), .dma_resetn(dma_resetn),
      .packetizer_resetn(packetizer_resetn), .pwr_en(pwr_en), .ref_en(ref_en),
      .io_en(io_en), .diffamp_en(diffamp_en), .opamp_en(opamp_en),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .s_axi_lite_awaddr(s_axi_lite_awaddr), .s_axi_lite_awprot(s_axi_lite_awprot),
      .s_axi_lite_awvalid(s_axi_lite_awvalid), .s_axi_lite_awready(s_axi_lite_awready),
      .s_axi_lite_wdata(s_axi_lite_wdata), .s_axi_lite_wstrb(s_axi_lite_wstrb),
      .s_axi_lite_wvalid(s_axi_lite_wvalid), .s_axi_lite_wready(s_axi_lite_wready),
      .s_axi_lite_bresp(s_axi_lite_bresp), .s_axi_lite_bvalid(s_axi_lite_bvalid),
      .s_axi_lite_bready(s_axi_lite_bready),
      .s_axi_lite_araddr(s_axi_lite_araddr), .s_axi_lite_arprot(s_axi_lite_arprot),
      .s_axi_lite_arvalid(s_axi_lite_arvalid), .s_axi_lite_arready(s_axi_lite_arready),
      .s_axi_lite_rdata(s_axi_lite_rdata), .s_axi_lite_rresp(s_axi_lite_rresp),
      .s_axi_lite_rvalid(s_axi_lite_rvalid), .s_axi_lite_rready(s_axi_lite_rready)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: no handshake within the cycle budget at %0t", name, $time);
   endtask

   function automatic void model_read(input logic [7:0] addr, output logic [31:0] d,
                                      output logic [1:0] r);
      int idx;
      idx = int'(addr[7:2]);
      d = '0;
      r = 2'b00;
      if (idx < NUM_CFG) d = m_cfg[idx];
      else if (idx >= 16 && idx < 16 + NUM_STATUS) d = status[32*(idx-16) +: 32];
      else if (idx == 32) d = m_last;
      else if (idx == 33) d = {13'd0, m_ovf, m_fifo.size() == 0, m_fifo.size() == DEPTH,
                               16'(m_fifo.size())};
      else if (idx == 34) d = {30'd0, m_ovf, 1'b0};
      else r = 2'b10;
   endfunction

   // Model and compare process: samples mid-cycle, checks outputs against the
   // model, then advances the model by the handshakes due at the next edge.
   initial begin
      logic [31:0] d;
      logic [1:0]  r, resp;
      logic [33:0] e;
      bit          pop_now, full_before, pop_done;
      int          widx;
      forever begin
         @(negedge aclk);
         #2;
         if (!aresetn) begin
            for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = '0;
            m_fifo.delete();
            exp_b.delete();
            exp_r.delete();
            m_ovf = 1'b0;
            m_last = '0;
            b_due = 1'b0;
            r_due = 1'b0;
         end else begin
            for (int k = 0; k < NUM_CFG; k++) check("cfg_word", cfg[32*k +: 32], m_cfg[k]);
            check("tvalid", m_axis_tvalid, m_fifo.size() > 0);
            if (m_fifo.size() > 0) check("tdata", m_axis_tdata, m_fifo[0]);
            check("block_resets", {packetizer_resetn, dma_resetn, adc_resetn}, m_cfg[0][2:0]);
            check("analog_enables", {opamp_en, diffamp_en, io_en, ref_en, pwr_en}, m_cfg[0][7:3]);
            if (b_due) begin
               check("bvalid_rise", s_axi_lite_bvalid, 1);
               b_due = 1'b0;
            end
            if (s_axi_lite_bvalid && s_axi_lite_bready) begin
               if (exp_b.size() > 0) check("bresp", s_axi_lite_bresp, exp_b.pop_front());
               else timeout_fail("bvalid_unexpected");
            end
            if (r_due) begin
               check("rvalid_rise", s_axi_lite_rvalid, 1);
               r_due = 1'b0;
            end
            if (s_axi_lite_rvalid && s_axi_lite_rready) begin
               if (exp_r.size() > 0) begin
                  e = exp_r.pop_front();
                  check("rdata", s_axi_lite_rdata, e[31:0]);
                  check("rresp", s_axi_lite_rresp, e[33:32]);
               end else timeout_fail("rvalid_unexpected");
            end
            if (s_axi_lite_awready) begin
               check("wready_with_awready", s_axi_lite_wready, 1);
               check("no_b_while_accepting", s_axi_lite_bvalid, 0);
            end
            if (s_axi_lite_rvalid) check("arready_low_in_read", s_axi_lite_arready, 0);

            pop_now     = m_axis_tready && m_fifo.size() > 0;
            full_before = m_fifo.size() == DEPTH;
            pop_done    = 1'b0;
            if (s_axi_lite_arvalid && s_axi_lite_arready) begin
               model_read(s_axi_lite_araddr, d, r);
               exp_r.push_back({r, d});
               r_due = 1'b1;
            end
            if (s_axi_lite_awvalid && s_axi_lite_wvalid && s_axi_lite_awready) begin
               widx = int'(s_axi_lite_awaddr[7:2]);
               resp = 2'b00;
               if (widx < NUM_CFG) begin
                  for (int b = 0; b < 4; b++)
                     if (s_axi_lite_wstrb[b]) m_cfg[widx][8*b +: 8] = s_axi_lite_wdata[8*b +: 8];
               end else if (widx == 32) begin
                  if (pop_now) void'(m_fifo.pop_front());
                  pop_done = 1'b1;
                  if (full_before && !pop_now) begin
                     m_ovf = 1'b1;
                     resp  = 2'b10;
                  end else begin
                     m_fifo.push_back(s_axi_lite_wdata);
                     m_last = s_axi_lite_wdata;
                  end
               end else if (widx == 34) begin
                  if (s_axi_lite_wdata[0]) begin
                     m_fifo.delete();
                     pop_done = 1'b1;
                  end
                  if (s_axi_lite_wdata[1]) m_ovf = 1'b0;
               end else resp = 2'b10;
               exp_b.push_back(resp);
               b_due = 1'b1;
            end
            if (pop_now && !pop_done) void'(m_fifo.pop_front());
         end
      end
   end

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit pop_at_accept,
                            input bit take_resp, output logic [1:0] resp);
      bit done;
      done = 1'b0;
      resp = 2'b11;
      s_axi_lite_awaddr  = addr;
      s_axi_lite_wdata   = data;
      s_axi_lite_wstrb   = strb;
      s_axi_lite_awvalid = 1'b1;
      s_axi_lite_wvalid  = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge aclk);
         if (s_axi_lite_awready) begin
            done = 1'b1;
            if (pop_at_accept) m_axis_tready = 1'b1;
         end
         @(posedge aclk);
         #1;
      end
      s_axi_lite_awvalid = 1'b0;
      s_axi_lite_wvalid  = 1'b0;
      if (pop_at_accept) m_axis_tready = 1'b0;
      if (!done) timeout_fail("aw_accept");
      if (take_resp) begin
         done = 1'b0;
         s_axi_lite_bready = 1'b1;
         for (int n = 0; n < 20 && !done; n++) begin
            @(negedge aclk);
            if (s_axi_lite_bvalid) begin
               resp = s_axi_lite_bresp;
               done = 1'b1;
            end
            @(posedge aclk);
            #1;
         end
         s_axi_lite_bready = 1'b0;
         if (!done) timeout_fail("b_response");
      end
   endtask

   task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit done;
      done = 1'b0;
      data = 'x;
      resp = 2'b11;
      s_axi_lite_araddr  = addr;
      s_axi_lite_arvalid = 1'b1;
      s_axi_lite_rready  = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge aclk);
         done = s_axi_lite_arready;
         @(posedge aclk);
         #1;
      end
      s_axi_lite_arvalid = 1'b0;
      if (!done) timeout_fail("ar_accept");
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge aclk);
         if (s_axi_lite_rvalid) begin
            data = s_axi_lite_rdata;
            resp = s_axi_lite_rresp;
            done = 1'b1;
         end
         @(posedge aclk);
         #1;
      end
      s_axi_lite_rready = 1'b0;
      if (!done) timeout_fail("r_response");
   endtask

   task automatic expect_read(input string name, input logic [7:0] addr,
                              input logic [31:0] exp_d, input logic [1:0] exp_r);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(addr, d, r);
      check(name, d, exp_d);
      check({name, "_resp"}, r, exp_r);
   endtask

   task automatic expect_write(input string name, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [1:0] exp_resp);
      logic [1:0] r;
      axi_write(addr, data, strb, 1'b0, 1'b1, r);
      check(name, r, exp_resp);
   endtask

   initial begin
      logic [1:0]  r;
      logic [31:0] d;
      logic [31:0] stream_exp [4];
      aresetn            = 1'b0;
      status             = '0;
      m_axis_tready      = 1'b0;
      s_axi_lite_awaddr  = '0;
      s_axi_lite_awprot  = '0;
      s_axi_lite_awvalid = 1'b0;
      s_axi_lite_wdata   = '0;
      s_axi_lite_wstrb   = '0;
      s_axi_lite_wvalid  = 1'b0;
      s_axi_lite_bready  = 1'b0;
      s_axi_lite_araddr  = '0;
      s_axi_lite_arprot  = '0;
      s_axi_lite_arvalid = 1'b0;
      s_axi_lite_rready  = 1'b0;
      #12;
      check("rst_cfg_lo", cfg[31:0], 0);
      check("rst_cfg_hi", cfg[63:32], 0);
      check("rst_handshakes", {s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bvalid,
                               s_axi_lite_arready, s_axi_lite_rvalid}, 0);
      check("rst_resps", {s_axi_lite_bresp, s_axi_lite_rresp}, 0);
      check("rst_rdata", s_axi_lite_rdata, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_block_resets", {adc_resetn, dma_resetn, packetizer_resetn}, 0);
      #10 aresetn = 1'b1;
      repeat (3) @(posedge aclk);
      #1;

      // Config word 0 with byte strobes and derived controls.
      expect_write("w_cfg0_b0", 8'h00, 32'h0000_00FF, 4'h1, 2'b00);
      expect_read("r_cfg0_ff", 8'h00, 32'h0000_00FF, 2'b00);
      check("ctrl_bits_all_on", {adc_resetn, dma_resetn, packetizer_resetn, pwr_en,
                                 ref_en, io_en, diffamp_en, opamp_en}, 8'hFF);
      expect_write("w_cfg0_b1", 8'h00, 32'h0000_AA00, 4'h2, 2'b00);
      expect_read("r_cfg0_aaff", 8'h00, 32'h0000_AAFF, 2'b00);
      expect_write("w_cfg1_full", 8'h04, 32'hDEAD_BEEF, 4'hF, 2'b00);
      expect_write("w_cfg1_b1", 8'h04, 32'h0000_1100, 4'h2, 2'b00);
      expect_read("r_cfg1_merge", 8'h04, 32'hDEAD_11EF, 2'b00);

      // Read and write paths active together.
      fork
         axi_write(8'h04, 32'h1234_5678, 4'hF, 1'b0, 1'b1, r);
         axi_read(8'h00, d, r);
      join
      check("concurrent_read", d, 32'h0000_AAFF);
      expect_read("r_cfg1_new", 8'h04, 32'h1234_5678, 2'b00);

      // Status words, RO and unmapped accesses.
      status = {32'h1234_5678, 32'hCAFE_F00D};
      expect_read("r_status1", 8'h44, 32'h1234_5678, 2'b00);
      expect_write("w_status1_err", 8'h44, 32'hFFFF_FFFF, 4'hF, 2'b10);
      expect_read("r_status1_same", 8'h44, 32'h1234_5678, 2'b00);
      expect_read("r_status0", 8'h40, 32'hCAFE_F00D, 2'b00);
      expect_read("r_unmapped", 8'h08, 32'h0, 2'b10);
      expect_write("w_unmapped_err", 8'h08, 32'h1, 4'hF, 2'b10);
      expect_write("w_level_err", 8'h84, 32'h1, 4'hF, 2'b10);

      // Fill, overflow, then drain back to back.
      stream_exp = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) expect_write("w_push", 8'h80, stream_exp[i], 4'h1, 2'b00);
      expect_read("r_level_full", 8'h84, 32'h0001_0004, 2'b00);
      expect_write("w_push_overflow", 8'h80, 32'h55, 4'hF, 2'b10);
      expect_read("r_level_ovf", 8'h84, 32'h0005_0004, 2'b00);
      expect_read("r_last_cmd", 8'h80, 32'h44, 2'b00);
      expect_read("r_ctrl_ovf", 8'h88, 32'h2, 2'b00);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         check("stream_valid", m_axis_tvalid, 1);
         check("stream_data", m_axis_tdata, stream_exp[i]);
         @(posedge aclk);
         #1;
      end
      @(negedge aclk);
      check("stream_done", m_axis_tvalid, 0);
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b0;
      expect_write("w_clr_ovf", 8'h88, 32'h2, 4'hF, 2'b00);
      expect_read("r_level_empty", 8'h84, 32'h0002_0000, 2'b00);

      // Push into a full FIFO while the head is being taken.
      for (int i = 1; i <= 4; i++) expect_write("w_fill", 8'h80, 32'hA0 + i, 4'hF, 2'b00);
      axi_write(8'h80, 32'hA5, 4'hF, 1'b1, 1'b1, r);
      check("w_push_full_pop", r, 2'b00);
      expect_read("r_level_full_pop", 8'h84, 32'h0001_0004, 2'b00);
      check("head_after_pop", m_axis_tdata, 32'hA2);

      // Flush and overflow clear.
      expect_write("w_flush", 8'h88, 32'h1, 4'hF, 2'b00);
      expect_read("r_level_flushed", 8'h84, 32'h0002_0000, 2'b00);
      for (int i = 1; i <= 3; i++) expect_write("w_push3", 8'h80, 32'hB0 + i, 4'hF, 2'b00);
      expect_read("r_level_three", 8'h84, 32'h0000_0003, 2'b00);
      expect_write("w_push4", 8'h80, 32'hB4, 4'hF, 2'b00);
      expect_write("w_push5_ovf", 8'h80, 32'hB5, 4'hF, 2'b10);
      expect_write("w_flush_clr", 8'h88, 32'h3, 4'hF, 2'b00);
      check("tvalid_after_flush", m_axis_tvalid, 0);
      expect_read("r_level_cleared", 8'h84, 32'h0002_0000, 2'b00);

      // Reset while a response is pending and commands are queued.
      expect_write("w_pre_rst_a", 8'h80, 32'hC1, 4'hF, 2'b00);
      expect_write("w_pre_rst_b", 8'h80, 32'hC2, 4'hF, 2'b00);
      axi_write(8'h00, 32'h0000_00FF, 4'hF, 1'b0, 1'b0, r);
      check("bvalid_pending", s_axi_lite_bvalid, 1);
      check("fifo_holds_two", m_axis_tvalid, 1);
      aresetn = 1'b0;
      #1;
      check("rst_mid_bvalid", s_axi_lite_bvalid, 0);
      check("rst_mid_cfg", cfg[31:0], 0);
      check("rst_mid_tvalid", m_axis_tvalid, 0);
      check("rst_mid_resets", {adc_resetn, dma_resetn, packetizer_resetn}, 0);
      #14 aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      expect_read("r_level_after_rst", 8'h84, 32'h0002_0000, 2'b00);
      expect_read("r_cfg0_after_rst", 8'h00, 32'h0, 2'b00);

      repeat (3) @(posedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

endmodule
